// File: rtl/cache_access_unit_if.sv
// Request, cache and register-file write-port signals of cache_access_unit.
// slave is the sequencer's view; master is the surrounding register file, cache and requester.
interface cache_access_unit_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int REGFILE_ADDR_WIDTH = 4
);
  logic                          REQ_VALID_I;
  logic                          REQ_READY_O;
  logic                          REQ_WRITE_I;
  logic [DATA_WIDTH-1:0]         REQ_ADDR_I;
  logic [DATA_WIDTH-1:0]         REQ_DATA_I;
  logic [REGFILE_ADDR_WIDTH-1:0] REQ_DEST_I;
  logic                          CACHE_VALID_O;
  logic                          CACHE_WR_O;
  logic [DATA_WIDTH-1:0]         CACHE_ADDR_O;
  logic [DATA_WIDTH-1:0]         CACHE_DATA_O;
  logic                          CACHE_ACK_I;
  logic [DATA_WIDTH-1:0]         CACHE_DATA_I;
  logic                          WR_PORT_EN_O;
  logic [REGFILE_ADDR_WIDTH-1:0] WR_PORT_ADDR_O;
  logic [DATA_WIDTH-1:0]         WR_PORT_DATA_O;
  logic                          BUSY_O;
  logic                          ERROR_O;

  modport slave (
    input  REQ_VALID_I, REQ_WRITE_I, REQ_ADDR_I, REQ_DATA_I, REQ_DEST_I,
    input  CACHE_ACK_I, CACHE_DATA_I,
    output REQ_READY_O, CACHE_VALID_O, CACHE_WR_O, CACHE_ADDR_O, CACHE_DATA_O,
    output WR_PORT_EN_O, WR_PORT_ADDR_O, WR_PORT_DATA_O, BUSY_O, ERROR_O
  );

  modport master (
    output REQ_VALID_I, REQ_WRITE_I, REQ_ADDR_I, REQ_DATA_I, REQ_DEST_I,
    output CACHE_ACK_I, CACHE_DATA_I,
    input  REQ_READY_O, CACHE_VALID_O, CACHE_WR_O, CACHE_ADDR_O, CACHE_DATA_O,
    input  WR_PORT_EN_O, WR_PORT_ADDR_O, WR_PORT_DATA_O, BUSY_O, ERROR_O
  );
endinterface

// File: rtl/cache_access_unit.sv
// Load/store sequencer between the register file and the data cache.
// Optional cache wait timeout with sticky error: define CACHE_TIMEOUT_EN.
module cache_access_unit #(
  parameter int DATA_WIDTH         = 32,
  parameter int REGFILE_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                EN_I,
  cache_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRBACK} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e                        state_q, state_d;
  logic                          wr_q, wr_d;
  logic [DATA_WIDTH-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;
  logic [REGFILE_ADDR_WIDTH-1:0] dest_q, dest_d;
`ifdef CACHE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dest_d  = dest_q;
`ifdef CACHE_TIMEOUT_EN
    cnt_d   = cnt_q;
    error_d = error_q;
`endif
    // With EN_I low nothing moves, including a pending ack.
    if (EN_I) begin
      case (state_q)
        IDLE: begin
          if (bus.REQ_VALID_I) begin
            wr_d    = bus.REQ_WRITE_I;
            addr_d  = bus.REQ_ADDR_I;
            wdata_d = bus.REQ_DATA_I;
            dest_d  = bus.REQ_DEST_I;
            state_d = ISSUE;
`ifdef CACHE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.CACHE_ACK_I) begin
            if (wr_q) begin
              state_d = IDLE;
            end else begin
              rdata_d = bus.CACHE_DATA_I;
              state_d = WRBACK;
            end
          end
`ifdef CACHE_TIMEOUT_EN
          else if (cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
        WRBACK:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dest_q  <= '0;
`ifdef CACHE_TIMEOUT_EN
      cnt_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dest_q  <= dest_d;
`ifdef CACHE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      error_q <= error_d;
`endif
    end
  end

  assign bus.REQ_READY_O    = (state_q == IDLE);
  assign bus.BUSY_O         = (state_q != IDLE);
  assign bus.CACHE_VALID_O  = (state_q == ISSUE);
  assign bus.CACHE_WR_O     = (state_q == ISSUE) && wr_q;
  assign bus.CACHE_ADDR_O   = addr_q;
  assign bus.CACHE_DATA_O   = wdata_q;
  assign bus.WR_PORT_EN_O   = (state_q == WRBACK);
  assign bus.WR_PORT_ADDR_O = dest_q;
  assign bus.WR_PORT_DATA_O = rdata_q;
`ifdef CACHE_TIMEOUT_EN
  assign bus.ERROR_O        = error_q;
`else
  assign bus.ERROR_O        = 1'b0;
`endif

endmodule
